// File: rtl/axi4_full_rd2umi_pkg.sv
// Shared constants, UMI command layout and pack helper
// for the AXI4 read-to-UMI bridge.
package axi4_full_rd2umi_pkg;

  localparam logic [4:0] UMI_REQ_READ  = 5'h01;
  localparam logic [4:0] UMI_RESP_READ = 5'h02;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [4:0] hostid;
    logic [1:0] err;
    logic       ex;
    logic       eof;
    logic       eom;
    logic [1:0] prot;
    logic [3:0] qos;
    logic [7:0] len;
    logic [2:0] size;
    logic [4:0] opcode;
  } umi_cmd_t;

  function automatic umi_cmd_t umi_pack(
    input logic [4:0] opcode,
    input logic [2:0] size,
    input logic [7:0] len,
    input logic [1:0] prot,
    input logic [3:0] qos,
    input logic       eom
  );
    umi_cmd_t c;
    c        = '0;
    c.opcode = opcode;
    c.size   = size;
    c.len    = len;
    c.prot   = prot;
    c.qos    = qos;
    c.eom    = eom;
    return c;
  endfunction

endpackage

// File: rtl/axi4_full_rd2umi_if.sv
// AXI4 read channels plus UMI host request/response
// bundle; slave is the bridge side, master the far side.
interface axi4_full_rd2umi_if #(
  parameter int CW  = 32,
  parameter int DW  = 128,
  parameter int AW  = 64,
  parameter int IDW = 8
);
  logic [IDW-1:0] s_axi_arid;
  logic [AW-1:0]  s_axi_araddr;
  logic [7:0]     s_axi_arlen;
  logic [2:0]     s_axi_arsize;
  logic [1:0]     s_axi_arburst;
  logic           s_axi_arlock;
  logic [3:0]     s_axi_arcache;
  logic [2:0]     s_axi_arprot;
  logic [3:0]     s_axi_arqos;
  logic           s_axi_arvalid;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready;
  logic           uhost_req_valid;
  logic           uhost_req_ready;
  logic [CW-1:0]  uhost_req_cmd;
  logic [AW-1:0]  uhost_req_dstaddr;
  logic [AW-1:0]  uhost_req_srcaddr;
  logic [DW-1:0]  uhost_req_data;
  logic           uhost_resp_valid;
  logic           uhost_resp_ready;
  logic [CW-1:0]  uhost_resp_cmd;
  logic [AW-1:0]  uhost_resp_dstaddr;
  logic [AW-1:0]  uhost_resp_srcaddr;
  logic [DW-1:0]  uhost_resp_data;

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen,
    input  s_axi_arsize, s_axi_arburst, s_axi_arlock,
    input  s_axi_arcache, s_axi_arprot, s_axi_arqos,
    input  s_axi_arvalid, s_axi_rready,
    output s_axi_arready, s_axi_rid, s_axi_rdata,
    output s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output uhost_req_valid, uhost_req_cmd,
    output uhost_req_dstaddr, uhost_req_srcaddr,
    output uhost_req_data, uhost_resp_ready,
    input  uhost_req_ready, uhost_resp_valid,
    input  uhost_resp_cmd, uhost_resp_dstaddr,
    input  uhost_resp_srcaddr, uhost_resp_data
  );

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen,
    output s_axi_arsize, s_axi_arburst, s_axi_arlock,
    output s_axi_arcache, s_axi_arprot, s_axi_arqos,
    output s_axi_arvalid, s_axi_rready,
    input  s_axi_arready, s_axi_rid, s_axi_rdata,
    input  s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  uhost_req_valid, uhost_req_cmd,
    input  uhost_req_dstaddr, uhost_req_srcaddr,
    input  uhost_req_data, uhost_resp_ready,
    output uhost_req_ready, uhost_resp_valid,
    output uhost_resp_cmd, uhost_resp_dstaddr,
    output uhost_resp_srcaddr, uhost_resp_data
  );
endinterface

// File: rtl/axi4_full_rd2umi_burst_addr.sv
// Combinational AXI burst next-address and beat byte count
// (bytes-1) for FIXED/INCR/WRAP; shared with the write side.
module axi4_burst_addr
  import axi4_full_rd2umi_pkg::*;
#(
  parameter int AW = 64
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic [7:0]    bytes_m1
);
  logic [AW-1:0] step;
  logic [AW-1:0] smask;
  logic [AW-1:0] incr;
  logic [AW-1:0] wmask;

  always_comb begin
    step  = AW'(1) << size;
    smask = step - AW'(1);
    incr  = (addr & ~smask) + step;
    wmask = ((AW'(len) + AW'(1)) << size) - AW'(1);
    // first beat may be unaligned: read only up to the size boundary
    bytes_m1 = 8'(smask - (addr & smask));
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wmask) | (incr & wmask);
      default:     next_addr = incr;
    endcase
  end
endmodule

// File: rtl/axi4_full_rd2umi.sv
// AXI4 full read slave: one UMI read request per AXI beat,
// each UMI response returned as one registered R beat.
module axi4_full_rd2umi
  import axi4_full_rd2umi_pkg::*;
#(
  parameter int          CW       = 32,
  parameter int          DW       = 128,
  parameter int          AW       = 64,
  parameter int          IDW      = 8,
  parameter logic [AW-1:0] HOSTADDR = {AW{1'b0}},
  parameter int          STRBW    = DW / 8
) (
  input logic clk,
  input logic nreset,
  axi4_full_rd2umi_if.slave bus
);
  localparam int SZW = $clog2(STRBW);

  localparam logic [1:0] IDLE          = 2'd0;
  localparam logic [1:0] UMI_READ      = 2'd1;
  localparam logic [1:0] WAIT_UMI_RESP = 2'd2;
  localparam logic [1:0] SEND_R        = 2'd3;

  logic [1:0]     state;
  logic [IDW-1:0] id_q;
  logic [AW-1:0]  addr_q;
  logic [7:0]     len_q;
  logic [2:0]     size_q;
  logic [1:0]     burst_q;
  logic [1:0]     prot_q;
  logic [3:0]     qos_q;
  logic [7:0]     cnt_q;
  logic [DW-1:0]  rdata_q;
  logic [1:0]     rresp_q;
  logic           rlast_q;

  logic [2:0]     size_in;
  logic [AW-1:0]  next_addr;
  logic [7:0]     bytes_m1;
  logic [SZW-1:0] lane;
  umi_cmd_t       resp_c;
  logic           unused_ok;

  assign size_in = (bus.s_axi_arsize > 3'(SZW)) ?
                   3'(SZW) : bus.s_axi_arsize;
  assign lane    = addr_q[SZW-1:0];
  assign resp_c  = umi_cmd_t'(bus.uhost_resp_cmd[31:0]);

  assign unused_ok = ^{bus.s_axi_arlock, bus.s_axi_arcache,
                       bus.s_axi_arprot[2], resp_c,
                       bus.uhost_resp_cmd,
                       bus.uhost_resp_dstaddr,
                       bus.uhost_resp_srcaddr};

  axi4_burst_addr #(.AW(AW)) u_addr (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .bytes_m1  (bytes_m1)
  );

  assign bus.s_axi_arready    = (state == IDLE);
  assign bus.uhost_req_valid  = (state == UMI_READ);
  assign bus.uhost_resp_ready = (state == WAIT_UMI_RESP);
  assign bus.s_axi_rvalid     = (state == SEND_R);

  assign bus.s_axi_rid   = id_q;
  assign bus.s_axi_rdata = rdata_q;
  assign bus.s_axi_rresp = rresp_q;
  assign bus.s_axi_rlast = rlast_q;

  assign bus.uhost_req_cmd = CW'(umi_pack(UMI_REQ_READ,
                                          3'd0, bytes_m1,
                                          prot_q, qos_q, 1'b1));
  assign bus.uhost_req_dstaddr = addr_q;
  assign bus.uhost_req_srcaddr = HOSTADDR;
  assign bus.uhost_req_data    = '0;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      qos_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rlast_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_axi_arvalid) begin
            id_q    <= bus.s_axi_arid;
            addr_q  <= bus.s_axi_araddr;
            len_q   <= bus.s_axi_arlen;
            size_q  <= size_in;
            burst_q <= bus.s_axi_arburst;
            prot_q  <= bus.s_axi_arprot[1:0];
            qos_q   <= bus.s_axi_arqos;
            cnt_q   <= '0;
            state   <= UMI_READ;
          end
        end
        UMI_READ: begin
          if (bus.uhost_req_ready) state <= WAIT_UMI_RESP;
        end
        WAIT_UMI_RESP: begin
          if (bus.uhost_resp_valid) begin
            rdata_q <= bus.uhost_resp_data << {lane, 3'b000};
            // a non-read response opcode is reported as SLVERR
            rresp_q <= (resp_c.opcode == UMI_RESP_READ) ?
                       resp_c.err : RESP_SLVERR;
            rlast_q <= (cnt_q == len_q);
            state   <= SEND_R;
          end
        end
        default: begin
          if (bus.s_axi_rready) begin
            if (rlast_q) begin
              state <= IDLE;
            end else begin
              addr_q <= next_addr;
              cnt_q  <= cnt_q + 8'd1;
              state  <= UMI_READ;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_full_rd2umi.sv
// Bench for axi4_full_rd2umi: directed and random bursts
// against an arithmetic AXI burst / UMI reference model.
`timescale 1ns/1ps
module tb_axi4_full_rd2umi;
  localparam int CW  = 32;
  localparam int DW  = 128;
  localparam int AW  = 64;
  localparam int IDW = 8;
  localparam logic [AW-1:0] HOST = 64'hABCD_0000_0000_1234;
  localparam logic [4:0] OP_RESP_RD = 5'h02;
  localparam logic [4:0] OP_RESP_WR = 5'h04;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  axi4_full_rd2umi_if #(.CW(CW), .DW(DW), .AW(AW), .IDW(IDW)) bus ();

  axi4_full_rd2umi #(
    .CW(CW), .DW(DW), .AW(AW), .IDW(IDW), .HOSTADDR(HOST)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] rsp_data [256];
  logic [1:0]    rsp_err  [256];
  logic [4:0]    rsp_op   [256];

  logic [AW-1:0]  o_dst [$];
  logic [CW-1:0]  o_cmd [$];
  logic [AW-1:0]  o_src [$];
  logic [DW-1:0]  o_qd  [$];
  logic [DW-1:0]  o_rd  [$];
  logic [1:0]     o_rr  [$];
  logic           o_rl  [$];
  logic [IDW-1:0] o_id  [$];
  int tmo, req_stall, r_stall;
  int req_unstable, r_unstable, req_in_rstall, ar_busy;

  function automatic int clamp_sz(input logic [2:0] s);
    return (s > 3'd4) ? 4 : int'(s);
  endfunction

  function automatic logic [AW-1:0] m_addr(
    input logic [AW-1:0] a, input logic [7:0] l,
    input logic [2:0] s, input logic [1:0] b, input int n);
    logic [AW-1:0] bytes, al, total, base;
    bytes = AW'(1) << clamp_sz(s);
    al    = a - (a % bytes);
    if (n == 0 || b == 2'b00) return a;
    if (b == 2'b10) begin
      total = (AW'(l) + 1) * bytes;
      base  = a - (a % total);
      return base + ((al + AW'(n) * bytes - base) % total);
    end
    return al + AW'(n) * bytes;
  endfunction

  function automatic logic [CW-1:0] m_cmd(
    input logic [AW-1:0] a, input logic [2:0] s,
    input logic [1:0] prot, input logic [3:0] qos);
    logic [AW-1:0] bytes;
    logic [CW-1:0] len;
    bytes = AW'(1) << clamp_sz(s);
    len   = CW'(bytes - (a % bytes) - 1);
    return 32'h0040_0001 | (CW'(prot) << 20) |
           (CW'(qos) << 16) | (len << 8);
  endfunction

  function automatic logic [DW-1:0] m_rdata(
    input logic [DW-1:0] d, input logic [AW-1:0] a);
    return d << (8 * int'(a % 16));
  endfunction

  function automatic logic [1:0] m_rresp(
    input logic [4:0] op, input logic [1:0] e);
    return (op != OP_RESP_RD) ? 2'b10 : e;
  endfunction

  task automatic do_burst(
    input logic [IDW-1:0] id, input logic [AW-1:0] a,
    input logic [7:0] l, input logic [2:0] s,
    input logic [1:0] b, input logic [2:0] prot,
    input logic [3:0] qos);
    int t;
    logic [CW-1:0] c0;
    logic [AW-1:0] d0;
    logic [DW-1:0] rd0;
    logic [1:0]    rr0;
    logic          rl0;
    o_dst.delete(); o_cmd.delete(); o_src.delete(); o_qd.delete();
    o_rd.delete(); o_rr.delete(); o_rl.delete(); o_id.delete();
    tmo = 0; req_unstable = 0; r_unstable = 0;
    req_in_rstall = 0; ar_busy = 0;
    @(negedge clk);
    bus.s_axi_arid = id; bus.s_axi_araddr = a;
    bus.s_axi_arlen = l; bus.s_axi_arsize = s;
    bus.s_axi_arburst = b; bus.s_axi_arprot = prot;
    bus.s_axi_arqos = qos; bus.s_axi_arvalid = 1'b1;
    t = 0;
    while (!bus.s_axi_arready && t < 50) begin
      @(negedge clk); t++;
    end
    if (!bus.s_axi_arready) begin tmo++; bus.s_axi_arvalid = 1'b0; return; end
    @(negedge clk);
    // keep arvalid high one more cycle: a second AR must not be taken
    if (bus.s_axi_arready) ar_busy++;
    bus.s_axi_arvalid = 1'b0;
    for (int n = 0; n <= int'(l); n++) begin
      t = 0;
      while (!bus.uhost_req_valid && t < 50) begin
        @(negedge clk); t++;
      end
      if (!bus.uhost_req_valid) begin tmo++; return; end
      c0 = bus.uhost_req_cmd; d0 = bus.uhost_req_dstaddr;
      repeat (req_stall) begin
        @(negedge clk);
        if (!bus.uhost_req_valid || bus.uhost_req_cmd !== c0 ||
            bus.uhost_req_dstaddr !== d0) req_unstable++;
        if (bus.s_axi_arready) ar_busy++;
      end
      o_cmd.push_back(bus.uhost_req_cmd);
      o_dst.push_back(bus.uhost_req_dstaddr);
      o_src.push_back(bus.uhost_req_srcaddr);
      o_qd.push_back(bus.uhost_req_data);
      bus.uhost_req_ready = 1'b1;
      @(negedge clk);
      bus.uhost_req_ready = 1'b0;
      bus.uhost_resp_valid = 1'b1;
      bus.uhost_resp_cmd = (CW'(rsp_err[n]) << 25) | CW'(rsp_op[n]);
      bus.uhost_resp_data = rsp_data[n];
      t = 0;
      while (!bus.uhost_resp_ready && t < 50) begin
        @(negedge clk); t++;
      end
      if (!bus.uhost_resp_ready) begin
        tmo++; bus.uhost_resp_valid = 1'b0; return;
      end
      @(negedge clk);
      bus.uhost_resp_valid = 1'b0;
      t = 0;
      while (!bus.s_axi_rvalid && t < 50) begin
        @(negedge clk); t++;
      end
      if (!bus.s_axi_rvalid) begin tmo++; return; end
      rd0 = bus.s_axi_rdata; rr0 = bus.s_axi_rresp; rl0 = bus.s_axi_rlast;
      repeat (r_stall) begin
        @(negedge clk);
        if (!bus.s_axi_rvalid || bus.s_axi_rdata !== rd0 ||
            bus.s_axi_rresp !== rr0 || bus.s_axi_rlast !== rl0)
          r_unstable++;
        if (bus.uhost_req_valid) req_in_rstall++;
      end
      o_rd.push_back(bus.s_axi_rdata);
      o_rr.push_back(bus.s_axi_rresp);
      o_rl.push_back(bus.s_axi_rlast);
      o_id.push_back(bus.s_axi_rid);
      bus.s_axi_rready = 1'b1;
      @(negedge clk);
      bus.s_axi_rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.s_axi_arready !== 1'b1 || bus.s_axi_rvalid !== 1'b0 ||
        bus.uhost_req_valid !== 1'b0 || bus.uhost_resp_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got ar=%b r=%b req=%b resp=%b exp 1 0 0 0",
               bus.s_axi_arready, bus.s_axi_rvalid,
               bus.uhost_req_valid, bus.uhost_resp_ready);
    end
    checks++;
    if (bus.s_axi_rdata !== '0 || bus.s_axi_rresp !== 2'b00 ||
        bus.s_axi_rid !== '0 || bus.s_axi_rlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_r got rdata=%h rresp=%b rid=%h rlast=%b exp zeros",
               bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rid, bus.s_axi_rlast);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_aligned_single();
    logic [DW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    rsp_data[0] = d; rsp_err[0] = 2'b00; rsp_op[0] = OP_RESP_RD;
    do_burst(8'h05, 64'h1000, 8'd0, 3'd4, 2'b01, 3'd0, 4'd0);
    checks++;
    if (tmo !== 0 || o_rd.size() !== 1) begin
      failures++;
      $display("FAIL single_beats got %0d tmo=%0d exp 1", o_rd.size(), tmo);
    end else begin
      checks++;
      if (o_dst[0] !== 64'h1000 || o_cmd[0] !== 32'h0040_0F01) begin
        failures++;
        $display("FAIL single_req got dst=%h cmd=%h exp 1000 00400f01",
                 o_dst[0], o_cmd[0]);
      end
      checks++;
      if (o_src[0] !== HOST || o_qd[0] !== '0) begin
        failures++;
        $display("FAIL single_src got src=%h data=%h exp %h 0",
                 o_src[0], o_qd[0], HOST);
      end
      checks++;
      if (o_rd[0] !== d || o_rl[0] !== 1'b1 || o_rr[0] !== 2'b00 ||
          o_id[0] !== 8'h05) begin
        failures++;
        $display("FAIL single_r got %h last=%b resp=%b id=%h exp %h 1 00 05",
                 o_rd[0], o_rl[0], o_rr[0], o_id[0], d);
      end
    end
  endtask

  task automatic test_incr();
    logic [DW-1:0] exp_rd [4];
    logic [DW-1:0] a;
    a = 128'hA;
    exp_rd[0] = a << 32; exp_rd[1] = a << 64;
    exp_rd[2] = a << 96; exp_rd[3] = a;
    for (int i = 0; i < 4; i++) begin
      rsp_data[i] = a; rsp_err[i] = 2'b00; rsp_op[i] = OP_RESP_RD;
    end
    do_burst(8'h11, 64'h1004, 8'd3, 3'd2, 2'b01, 3'd0, 4'd0);
    checks++;
    if (tmo !== 0 || o_rd.size() !== 4) begin
      failures++;
      $display("FAIL incr_beats got %0d tmo=%0d exp 4", o_rd.size(), tmo);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_dst[i] !== 64'h1004 + 64'(4 * i) ||
            o_cmd[i][15:8] !== 8'd3 || o_rd[i] !== exp_rd[i] ||
            o_rl[i] !== (i == 3)) begin
          failures++;
          $display("FAIL incr[%0d] got dst=%h len=%0d rd=%h last=%b exp rd=%h",
                   i, o_dst[i], o_cmd[i][15:8], o_rd[i], o_rl[i], exp_rd[i]);
        end
      end
    end
  endtask

  task automatic test_unaligned();
    for (int i = 0; i < 2; i++) begin
      rsp_data[i] = 128'h1234; rsp_err[i] = 2'b00; rsp_op[i] = OP_RESP_RD;
    end
    do_burst(8'h22, 64'h1002, 8'd1, 3'd2, 2'b01, 3'd0, 4'd0);
    checks++;
    if (tmo !== 0 || o_rd.size() !== 2) begin
      failures++;
      $display("FAIL unal_beats got %0d tmo=%0d exp 2", o_rd.size(), tmo);
    end else begin
      checks++;
      if (o_dst[0] !== 64'h1002 || o_cmd[0][15:8] !== 8'd1 ||
          o_dst[1] !== 64'h1004 || o_cmd[1][15:8] !== 8'd3) begin
        failures++;
        $display("FAIL unal_req got %h/%0d %h/%0d exp 1002/1 1004/3",
                 o_dst[0], o_cmd[0][15:8], o_dst[1], o_cmd[1][15:8]);
      end
      checks++;
      if (o_rd[0] !== (128'h1234 << 16)) begin
        failures++;
        $display("FAIL unal_rdata got %h exp %h", o_rd[0], 128'h1234 << 16);
      end
    end
  endtask

  task automatic test_wrap_fixed();
    logic [AW-1:0] ew [4];
    ew[0] = 64'h1008; ew[1] = 64'h100C; ew[2] = 64'h1000; ew[3] = 64'h1004;
    for (int i = 0; i < 4; i++) begin
      rsp_data[i] = 128'(i + 1); rsp_err[i] = 2'b00; rsp_op[i] = OP_RESP_RD;
    end
    for (int k = 0; k < 2; k++) begin
      do_burst(8'h33, 64'h1008, 8'd3, 3'd2, (k == 0) ? 2'b10 : 2'b00,
               3'd0, 4'd0);
      checks++;
      if (tmo !== 0 || o_dst.size() !== 4) begin
        failures++;
        $display("FAIL wrapfix_beats[%0d] got %0d exp 4", k, o_dst.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (o_dst[i] !== ((k == 0) ? ew[i] : 64'h1008)) begin
            failures++;
            $display("FAIL wrapfix_dst[%0d][%0d] got %h exp %h", k, i,
                     o_dst[i], (k == 0) ? ew[i] : 64'h1008);
          end
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [1:0] er [3];
    er[0] = 2'b00; er[1] = 2'b10; er[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      rsp_data[i] = 128'hBEEF; rsp_err[i] = er[i]; rsp_op[i] = OP_RESP_RD;
    end
    do_burst(8'h44, 64'h2000, 8'd2, 3'd4, 2'b01, 3'd0, 4'd0);
    checks++;
    if (tmo !== 0 || o_rr.size() !== 3) begin
      failures++;
      $display("FAIL err_beats got %0d tmo=%0d exp 3", o_rr.size(), tmo);
    end else begin
      checks++;
      if (o_rr[0] !== 2'b00 || o_rr[1] !== 2'b10 || o_rr[2] !== 2'b00 ||
          o_rl[2] !== 1'b1) begin
        failures++;
        $display("FAIL err_rresp got %b %b %b last=%b exp 00 10 00 1",
                 o_rr[0], o_rr[1], o_rr[2], o_rl[2]);
      end
    end
    rsp_err[0] = 2'b00; rsp_op[0] = OP_RESP_WR;
    do_burst(8'h45, 64'h3000, 8'd0, 3'd4, 2'b01, 3'd0, 4'd0);
    checks++;
    if (tmo !== 0 || o_rr.size() !== 1 || o_rr[0] !== 2'b10) begin
      failures++;
      $display("FAIL err_opcode got n=%0d rresp=%b exp 1 10",
               o_rr.size(), (o_rr.size() > 0) ? o_rr[0] : 2'bxx);
    end
  endtask

  task automatic test_stalls();
    req_stall = 3; r_stall = 5;
    for (int i = 0; i < 2; i++) begin
      rsp_data[i] = {$urandom, $urandom, $urandom, $urandom};
      rsp_err[i] = 2'b01; rsp_op[i] = OP_RESP_RD;
    end
    do_burst(8'h55, 64'h4010, 8'd1, 3'd4, 2'b01, 3'd2, 4'hC);
    req_stall = 0; r_stall = 0;
    checks++;
    if (tmo !== 0 || req_unstable !== 0 || r_unstable !== 0) begin
      failures++;
      $display("FAIL stall_stable got tmo=%0d req=%0d r=%0d exp 0 0 0",
               tmo, req_unstable, r_unstable);
    end
    checks++;
    if (req_in_rstall !== 0 || ar_busy !== 0) begin
      failures++;
      $display("FAIL stall_block got req=%0d ar=%0d exp 0 0",
               req_in_rstall, ar_busy);
    end
    checks++;
    if (o_rd.size() !== 2 || o_rd[1] !== rsp_data[1] || o_rr[1] !== 2'b01 ||
        o_cmd[0] !== m_cmd(64'h4010, 3'd4, 2'd2, 4'hC)) begin
      failures++;
      $display("FAIL stall_data got n=%0d exp 2 beats with model data",
               o_rd.size());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    @(negedge clk);
    bus.s_axi_araddr = 64'h5000; bus.s_axi_arlen = 8'd3;
    bus.s_axi_arsize = 3'd4; bus.s_axi_arburst = 2'b01;
    bus.s_axi_arvalid = 1'b1;
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    t = 0;
    while (!bus.uhost_req_valid && t < 50) begin @(negedge clk); t++; end
    bus.uhost_req_ready = 1'b1;
    @(negedge clk);
    bus.uhost_req_ready = 1'b0;
    checks++;
    if (bus.uhost_resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_wait got resp_ready=%b exp 1", bus.uhost_resp_ready);
    end
    nreset = 1'b0;
    #1;
    checks++;
    if (bus.s_axi_arready !== 1'b1 || bus.uhost_req_valid !== 1'b0 ||
        bus.s_axi_rvalid !== 1'b0 || bus.uhost_resp_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst got ar=%b req=%b r=%b resp=%b exp 1 0 0 0",
               bus.s_axi_arready, bus.uhost_req_valid,
               bus.s_axi_rvalid, bus.uhost_resp_ready);
    end
    @(negedge clk);
    nreset = 1'b1;
    rsp_data[0] = 128'hC0FFEE; rsp_err[0] = 2'b00; rsp_op[0] = OP_RESP_RD;
    do_burst(8'h66, 64'h6000, 8'd0, 3'd4, 2'b01, 3'd0, 4'd0);
    checks++;
    if (tmo !== 0 || o_rd.size() !== 1 || o_rd[0] !== 128'hC0FFEE) begin
      failures++;
      $display("FAIL midrst_recover got n=%0d tmo=%0d exp one C0FFEE beat",
               o_rd.size(), tmo);
    end
  endtask

  task automatic test_random();
    logic [IDW-1:0] id;
    logic [AW-1:0]  a, ea;
    logic [7:0]     l;
    logic [2:0]     s, prot;
    logic [1:0]     b;
    logic [3:0]     qos;
    int bad;
    for (int it = 0; it < 25; it++) begin
      id = 8'($urandom); a = {$urandom, $urandom};
      s = 3'($urandom_range(0, 6)); b = 2'($urandom_range(0, 2));
      prot = 3'($urandom); qos = 4'($urandom);
      if (b == 2'b10) l = 8'((2 << $urandom_range(0, 2)) - 1);
      else l = 8'($urandom_range(0, 6));
      for (int i = 0; i <= int'(l); i++) begin
        rsp_data[i] = {$urandom, $urandom, $urandom, $urandom};
        rsp_err[i] = 2'($urandom);
        rsp_op[i] = ($urandom_range(0, 7) == 0) ? OP_RESP_WR : OP_RESP_RD;
      end
      req_stall = $urandom_range(0, 2); r_stall = $urandom_range(0, 2);
      do_burst(id, a, l, s, b, prot, qos);
      checks++;
      if (tmo !== 0 || o_rd.size() !== int'(l) + 1) begin
        failures++;
        $display("FAIL rand_beats[%0d] got %0d tmo=%0d exp %0d",
                 it, o_rd.size(), tmo, int'(l) + 1);
        continue;
      end
      bad = 0;
      for (int i = 0; i <= int'(l); i++) begin
        ea = m_addr(a, l, s, b, i);
        if (o_dst[i] !== ea || o_cmd[i] !== m_cmd(ea, s, prot[1:0], qos) ||
            o_rd[i] !== m_rdata(rsp_data[i], ea) ||
            o_rr[i] !== m_rresp(rsp_op[i], rsp_err[i]) ||
            o_rl[i] !== (i == int'(l)) || o_id[i] !== id) begin
          if (bad == 0)
            $display("FAIL rand[%0d] beat %0d got dst=%h cmd=%h rd=%h rr=%b exp dst=%h cmd=%h rd=%h",
                     it, i, o_dst[i], o_cmd[i], o_rd[i], o_rr[i], ea,
                     m_cmd(ea, s, prot[1:0], qos), m_rdata(rsp_data[i], ea));
          bad++;
        end
      end
      checks++;
      if (bad !== 0) failures++;
    end
    req_stall = 0; r_stall = 0;
  endtask

  initial begin
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_arsize = '0; bus.s_axi_arburst = '0; bus.s_axi_arlock = 1'b0;
    bus.s_axi_arcache = '0; bus.s_axi_arprot = '0; bus.s_axi_arqos = '0;
    bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
    bus.uhost_req_ready = 1'b0; bus.uhost_resp_valid = 1'b0;
    bus.uhost_resp_cmd = '0; bus.uhost_resp_dstaddr = '0;
    bus.uhost_resp_srcaddr = '0; bus.uhost_resp_data = '0;
    req_stall = 0; r_stall = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_aligned_single();
    test_incr();
    test_unaligned();
    test_wrap_fixed();
    test_errors();
    test_stalls();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi4_full_rd2umi.md
Name: axi4_full_rd2umi

Overview:
- AXI4 full read-channel slave that converts AR bursts into UMI read requests on a UMI host port.
- Issues one UMI read request per AXI beat and waits for its UMI response.
- Returns each response as one R beat, then moves to the next beat.
- Read-side companion of the AXI4 write-to-UMI adapter; the two together form a complete AXI4 full slave bridge.

Parameters:
- CW, 32, UMI command width
- DW, 128, data width (AXI and UMI); must be ≤1024
- AW, 64, address width
- IDW, 8, AXI ID width
- HOSTADDR, {AW{1'b0}}, value driven on uhost_req_srcaddr
- STRBW, DW/8, derived; do not override

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- s_axi_arid  in  IDW  read ID
- s_axi_araddr  in  AW  start address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  log2 bytes/beat
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_arlock/arcache  in  1/4  ignored
- s_axi_arprot  in  3  [1:0] → cmd_prot
- s_axi_arqos  in  4  → cmd_qos
- s_axi_arvalid/arready  in/out  1  AR handshake
- s_axi_rid  out  IDW  latched arid
- s_axi_rdata  out  DW  beat data
- s_axi_rresp  out  2  response
- s_axi_rlast  out  1  final beat
- s_axi_rvalid/rready  out/in  1  R handshake
- uhost_req_valid/ready  out/in  1  UMI request handshake
- uhost_req_cmd  out  CW  UMI command
- uhost_req_dstaddr  out  AW  beat address
- uhost_req_srcaddr  out  AW  HOSTADDR
- uhost_req_data  out  DW  zero
- uhost_resp_valid/ready  in/out  1  UMI response handshake
- uhost_resp_cmd  in  CW  response command
- uhost_resp_dstaddr/srcaddr  in  AW  ignored
- uhost_resp_data  in  DW  read data, LSB-aligned

Behaviour:
- FSM states:
  - IDLE: arready=1. On ar fire, latch id, addr, len, size (clamped to log2 STRBW), burst, prot[1:0], qos; beat counter=0. Go to UMI_READ.
  - UMI_READ: req_valid=1. On req fire → WAIT_UMI_RESP.
  - WAIT_UMI_RESP: resp_ready=1. On resp fire, register rdata, rresp, rlast → SEND_R.
  - SEND_R: rvalid=1. On r fire with rlast → IDLE; otherwise advance address and counter → UMI_READ.
- Latency: no combinational path from AXI inputs to UMI outputs or from UMI to R. At least 1 cycle per state.
- Outputs at and after reset (state=IDLE): arready=1; rvalid, rlast, req_valid, resp_ready=0; rdata, rresp, rid=0.
- UMI request command:
  - opcode UMI_REQ_READ, size=0, eom=1.
  - len = bytes-1, where bytes = (1<<size) − (addr mod (1<<size)). Unaligned first beat reads up to the size boundary.
  - prot/qos from AR; all other fields 0.
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: addr = aligned(addr) + (1<<size).
  - WRAP: mask = ((arlen+1)<<size)−1; addr = (addr & ~mask) | ((aligned(addr)+(1<<size)) & mask).
- rdata = resp_data << 8*(addr mod STRBW). Unused lanes are 0.
- rresp = resp_cmd err field (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR).
  - If resp opcode ≠ UMI_RESP_READ, rresp=10.
  - On error the burst continues and all arlen+1 beats are returned.
- rlast=1 when beat counter == latched arlen.
- Held state:
  - rvalid held with rdata/rresp/rlast/rid stable until rready.
  - req_valid held with stable cmd/addr until ready.
  - resp_ready=0 outside WAIT_UMI_RESP; stray responses stall and are not dropped.
- arvalid during an active burst is not accepted; one outstanding burst only.
- nreset mid-burst: immediate return to IDLE, all valids 0. Any in-flight UMI response is the system's responsibility.

Decomposition:
- Opcode/field constants come from umi_messages.vh.
- Command encoding via existing umi_pack; response field extraction via umi_unpack.
- Add a local sub-module axi4_burst_addr (combinational next-address/beat-bytes for FIXED/INCR/WRAP) for reuse by the write adapter.

Test Plan:
1. Aligned single beat: DW=128, araddr=0x1000, arlen=0, arsize=4, arid=0x5, resp data=D, err=00 → one request (dst 0x1000, len 15); rdata=D, rlast=1, rresp=00, rid=0x5.
2. INCR: araddr=0x1004, arlen=3, arsize=2 → dst 0x1004/0x1008/0x100C/0x1010, len 3 each; resp data 0xA → rdata 0xA<<32, 0xA<<64, 0xA<<96, 0xA; rlast only on the 4th beat.
3. Unaligned INCR: araddr=0x1002, arlen=1, arsize=2 → dst 0x1002 len 1, then dst 0x1004 len 3.
4. WRAP: araddr=0x1008, arlen=3, arsize=2 → dst 0x1008, 0x100C, 0x1000, 0x1004. FIXED with same AR → 0x1008 four times.
5. Errors: 3-beat burst, 2nd response err=10 → rresp 00,10,00 and 3 beats returned. Response opcode ≠ RESP_READ → rresp=10.
6. Stalls and reset: hold rready=0 for 5 cycles → rvalid/rdata stable, no new request; hold req_ready=0 → request stable; assert nreset in WAIT_UMI_RESP → arready=1, other valids 0 immediately.
